pipe_delay_line: RTL

Parametrised multi-channel delay line with valid tracking, stall, flush and a runtime-selectable latency. It is the successor to the fixed-latency delay stage and is used to align control and data fields across pipeline stages of the MIPS datapath. Latency is chosen per cycle from 1 to MAX_DELAY.

---
 rtl/pipe_delay_line.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipe_delay_line.sv
// pipe_delay_line: multi-channel delay line with valid tracking, stall, flush
// and a per-cycle selectable output tap (latency 1..MAX_DELAY).
// Optional feature macro: PIPE_DELAY_PARITY_EN adds per-channel even parity
// storage and the parity_err output.
module pipe_delay_line #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned MAX_DELAY = 8,
  parameter int unsigned DELAY_W   = $clog2(MAX_DELAY + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_n,
  input  logic                          flush,
  input  logic [DELAY_W-1:0]            delay_sel,
  input  logic                          valid_in,
  input  logic [BIT_WIDTH*CHANNELS-1:0] dataIn,
  output logic                          valid_out,
  output logic [BIT_WIDTH*CHANNELS-1:0] dataOut,
  output logic [DELAY_W-1:0]            inflight
`ifdef PIPE_DELAY_PARITY_EN
  ,
  output logic [CHANNELS-1:0]           parity_err
`endif
);

  localparam int unsigned DATA_W = BIT_WIDTH * CHANNELS;

  logic [MAX_DELAY-1:0]             stage_valid;
  logic [MAX_DELAY-1:0][DATA_W-1:0] stage_data;
  logic [DELAY_W-1:0]               tap_sel;

  // Map requested latency to a tap index, clamping 0 up to 1 and large values to MAX_DELAY
  always_comb begin
    tap_sel = delay_sel - DELAY_W'(1);
    if (delay_sel == '0) begin
      tap_sel = '0;
    end else if (delay_sel > DELAY_W'(MAX_DELAY)) begin
      tap_sel = DELAY_W'(MAX_DELAY - 1);
    end
  end

  // Output tap mux straight from the stage registers, no extra latency
  always_comb begin
    valid_out = 1'b0;
    dataOut   = '0;
    for (int i = 0; i < int'(MAX_DELAY); i++) begin
      if (tap_sel == DELAY_W'(i)) begin
        valid_out = stage_valid[i];
        dataOut   = stage_data[i];
      end
    end
  end

  // Stage shift register and in-flight counter; reset and flush both clear everything
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      stage_valid <= '0;
      stage_data  <= '0;
      inflight    <= '0;
    end else if (!en_n) begin
      stage_valid[0] <= valid_in;
      stage_data[0]  <= dataIn;
      for (int i = 1; i < int'(MAX_DELAY); i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
      inflight <= inflight + DELAY_W'(valid_in) - DELAY_W'(stage_valid[MAX_DELAY-1]);
    end
  end

`ifdef PIPE_DELAY_PARITY_EN
  logic [MAX_DELAY-1:0][CHANNELS-1:0] stage_par;
  logic [CHANNELS-1:0]                tap_par;

  // Even parity per channel slice
  function automatic logic [CHANNELS-1:0] calc_parity(input logic [DATA_W-1:0] d);
    logic [CHANNELS-1:0] p;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      p[c] = ^d[c*BIT_WIDTH +: BIT_WIDTH];
    end
    return p;
  endfunction

  // Parity bits travel alongside the data stages
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      stage_par <= '0;
    end else if (!en_n) begin
      stage_par[0] <= calc_parity(dataIn);
      for (int i = 1; i < int'(MAX_DELAY); i++) begin
        stage_par[i] <= stage_par[i-1];
      end
    end
  end

  // Select stored parity of the active tap
  always_comb begin
    tap_par = '0;
    for (int i = 0; i < int'(MAX_DELAY); i++) begin
      if (tap_sel == DELAY_W'(i)) begin
        tap_par = stage_par[i];
      end
    end
  end

  // Report mismatches only for valid output words
  always_comb begin
    parity_err = '0;
    if (valid_out) begin
      parity_err = tap_par ^ calc_parity(dataOut);
    end
  end
`endif

endmodule
